// File: rtl/clk_strobe_gen_pkg.sv
// Shared configuration for the pixel-domain strobe generator: clock rates, NCO sizing and
// the helper that turns a target tick rate into a phase increment.
package clk_strobe_gen_pkg;

  localparam int unsigned CLKFRQ           = 27000;  // pixel clock in kHz
  localparam int unsigned AUDIO_RATE       = 48000;  // audio sample rate in Hz
  localparam int unsigned STROBE_ACC_WIDTH = 32;
  localparam int unsigned STROBE_CHANNELS  = 2;

  // round(f_tick * 2^w / f_clk), with f_clk given in kHz
  function automatic longint unsigned calc_inc(input longint unsigned f_clk_khz,
                                               input longint unsigned f_tick_hz,
                                               input int unsigned     w);
    longint unsigned den;
    den = f_clk_khz * 64'd1000;
    return ((f_tick_hz << w) + (den >> 1)) / den;
  endfunction

  // Tick at twice the audio rate so the toggled square clock lands on AUDIO_RATE.
  localparam int unsigned STROBE_INC_DEFAULT =
      32'(calc_inc(64'(CLKFRQ), 64'(2 * AUDIO_RATE), STROBE_ACC_WIDTH));

endpackage

// File: rtl/clk_strobe_gen_nco_channel.sv
// One NCO channel: phase accumulator with clamped increment register, registered overflow
// tick and a square clock that toggles on every tick.
module clk_strobe_gen_nco_channel #(
  parameter int unsigned W         = 32,
  parameter int unsigned INC_RESET = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         run_ok_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic         sync_i,
  input  logic [W-1:0] inc_i,
  output logic         tick_o,
  output logic         clk_o
);

  // Increments above half scale would allow back-to-back ticks, breaking the toggled clock.
  localparam logic [W-1:0] HalfScale = W'(64'd1 << (W - 1));
  localparam logic [W-1:0] IncReset  =
      (64'(INC_RESET) > (64'd1 << (W - 1))) ? HalfScale : W'(INC_RESET);

  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] inc_q, inc_d;
  logic         tick_q, tick_d;
  logic         sclk_q, sclk_d;
  logic [W:0]   sum;

  always_comb begin
    sum    = {1'b0, acc_q} + {1'b0, inc_q};
    acc_d  = acc_q;
    tick_d = 1'b0;
    sclk_d = sclk_q;
    inc_d  = inc_q;

    if (load_i) begin
      inc_d = (inc_i > HalfScale) ? HalfScale : inc_i;
    end

    if (!run_ok_i || sync_i) begin
      acc_d  = '0;
      sclk_d = 1'b0;
    end else if (en_i) begin
      // Modular wrap keeps the remainder, so the long-term rate is exact.
      acc_d  = sum[W-1:0];
      tick_d = sum[W];
      if (sum[W]) begin
        sclk_d = ~sclk_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      inc_q  <= IncReset;
      tick_q <= 1'b0;
      sclk_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      inc_q  <= inc_d;
      tick_q <= tick_d;
      sclk_q <= sclk_d;
    end
  end

  assign tick_o = tick_q;
  assign clk_o  = sclk_q;

endmodule

// File: rtl/clk_strobe_gen.sv
// Multi-channel fractional clock-enable generator: startup gate plus CHANNELS independent NCOs
// producing a 1-cycle tick and a half-rate square clock each.
module clk_strobe_gen
  import clk_strobe_gen_pkg::*;
#(
  parameter int unsigned CHANNELS       = STROBE_CHANNELS,
  parameter int unsigned ACC_WIDTH      = STROBE_ACC_WIDTH,
  parameter int unsigned STARTUP_CYCLES = 1024,
  parameter int unsigned INC_DEFAULT    = STROBE_INC_DEFAULT
) (
  input  logic                          I_clk_pixel,
  input  logic                          I_reset,
  input  logic [CHANNELS-1:0]           I_en,
  input  logic [CHANNELS-1:0]           I_load,
  input  logic [CHANNELS*ACC_WIDTH-1:0] I_inc,
  input  logic [CHANNELS-1:0]           I_sync,
  output logic                          O_ready,
  output logic [CHANNELS-1:0]           O_tick,
  output logic [CHANNELS-1:0]           O_clk
);

  localparam int unsigned CntW = $clog2(STARTUP_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ready_q, ready_d;

  // Counter stops once ready so the gate can never reopen without a reset.
  always_comb begin
    cnt_d   = cnt_q;
    ready_d = ready_q;
    if (!ready_q) begin
      cnt_d = cnt_q + CntW'(1);
      if (cnt_q == CntW'(STARTUP_CYCLES - 1)) begin
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge I_clk_pixel or posedge I_reset) begin
    if (I_reset) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign O_ready = ready_q;

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    clk_strobe_gen_nco_channel #(
      .W         (ACC_WIDTH),
      .INC_RESET (INC_DEFAULT)
    ) u_ch (
      .clk_i    (I_clk_pixel),
      .rst_i    (I_reset),
      .run_ok_i (ready_q),
      .en_i     (I_en[n]),
      .load_i   (I_load[n]),
      .sync_i   (I_sync[n]),
      .inc_i    (I_inc[n*ACC_WIDTH +: ACC_WIDTH]),
      .tick_o   (O_tick[n]),
      .clk_o    (O_clk[n])
    );
  end

endmodule

// File: tb/tb_clk_strobe_gen.sv
// Directed bench for clk_strobe_gen with a 4-bit accumulator so every overflow is hand-traceable.
module tb_clk_strobe_gen;

  localparam int unsigned CH = 2;
  localparam int unsigned W  = 4;
  localparam int unsigned SU = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [CH-1:0]   en, load, sync;
  logic [CH*W-1:0] inc;
  logic            ready;
  logic [CH-1:0]   tick, sclk;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned t_cnt;
  logic [15:0] pat;

  always #5 clk = ~clk;

  clk_strobe_gen #(
    .CHANNELS       (CH),
    .ACC_WIDTH      (W),
    .STARTUP_CYCLES (SU),
    .INC_DEFAULT    (3)
  ) dut (
    .I_clk_pixel (clk),
    .I_reset     (rst),
    .I_en        (en),
    .I_load      (load),
    .I_inc       (inc),
    .I_sync      (sync),
    .O_ready     (ready),
    .O_tick      (tick),
    .O_clk       (sclk)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = '0; load = '0; sync = '0; inc = '0;
    step(); step();
    check("rst_ready", 32'(ready), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_clk", 32'(sclk), 0);

    // Release; load ch0 inc=5 and enable it while still gated.
    rst = 1'b0; load = 2'b01; inc[3:0] = 4'd5; en = 2'b01;
    step();
    load = '0;
    for (int i = 2; i < SU; i++) step();
    check("startup_ready_lo", 32'(ready), 0);
    check("startup_tick_gated", 32'(tick), 0);
    step();
    check("startup_ready_hi", 32'(ready), 1);

    // inc=5: overflows on adds 4,7,10,13,16.
    pat = 16'h9248;
    t_cnt = 0;
    for (int n = 0; n < 16; n++) begin
      step();
      check("inc5_tick", 32'(tick[0]), 32'(pat[n]));
      t_cnt += 32'(tick[0]);
    end
    check("inc5_count", t_cnt, 5);
    check("inc5_clk", 32'(sclk[0]), 1);
    check("ch1_idle_tick", 32'(tick[1]), 0);
    check("ch1_idle_clk", 32'(sclk[1]), 0);

    // acc -> 5, 10, then freeze.
    step(); check("pre_freeze_a", 32'(tick[0]), 0);
    step(); check("pre_freeze_b", 32'(tick[0]), 0);
    en[0] = 1'b0;
    t_cnt = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      t_cnt += 32'(tick[0]);
    end
    check("freeze_ticks", t_cnt, 0);
    check("freeze_clk", 32'(sclk[0]), 1);
    en[0] = 1'b1;
    step(); check("resume_15", 32'(tick[0]), 0);
    step(); check("resume_wrap", 32'(tick[0]), 1);
    check("resume_clk", 32'(sclk[0]), 0);

    // acc=4: 9,14,3(tick),8,13 then sync where 18 would overflow.
    pat = 16'h0004;
    for (int n = 0; n < 5; n++) begin
      step();
      check("presync_tick", 32'(tick[0]), 32'(pat[n]));
    end
    check("presync_clk", 32'(sclk[0]), 1);
    sync[0] = 1'b1;
    step();
    sync[0] = 1'b0;
    check("sync_tick", 32'(tick[0]), 0);
    check("sync_clk", 32'(sclk[0]), 0);
    pat = 16'h0008;
    for (int n = 0; n < 4; n++) begin
      step();
      check("postsync_tick", 32'(tick[0]), 32'(pat[n]));
    end
    check("postsync_clk", 32'(sclk[0]), 1);

    // Load 15 together with sync: clamps to 8, acc cleared.
    load[0] = 1'b1; inc[3:0] = 4'd15; sync[0] = 1'b1;
    step();
    load[0] = 1'b0; sync[0] = 1'b0;
    check("ldsync_tick", 32'(tick[0]), 0);
    check("ldsync_clk", 32'(sclk[0]), 0);
    pat = 16'h002A;
    for (int n = 0; n < 6; n++) begin
      step();
      check("clamp_tick", 32'(tick[0]), 32'(pat[n]));
    end
    check("clamp_clk", 32'(sclk[0]), 1);

    // inc=0: the load cycle still adds 8 (acc 0->8), then nothing.
    load[0] = 1'b1; inc[3:0] = 4'd0;
    step();
    load[0] = 1'b0;
    check("zero_load_cycle", 32'(tick[0]), 0);
    t_cnt = 0;
    for (int n = 0; n < 8; n++) begin
      step();
      t_cnt += 32'(tick[0]);
    end
    check("zero_ticks", t_cnt, 0);
    check("zero_clk", 32'(sclk[0]), 1);

    // ch1: enable and load 8 together; first add uses old inc 3.
    en[1] = 1'b1; load[1] = 1'b1; inc[7:4] = 4'd8;
    step();
    load[1] = 1'b0;
    check("ld1_first_add", 32'(tick[1]), 0);
    pat = 16'h002A;
    t_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      step();
      check("ld1_tick", 32'(tick[1]), 32'(pat[n]));
      t_cnt += 32'(tick[0]);
    end
    check("ld1_clk", 32'(sclk[1]), 1);
    check("ch0_unaffected_ticks", t_cnt, 0);
    check("ch0_unaffected_clk", 32'(sclk[0]), 1);

    // Asynchronous reset mid-run, away from any clock edge.
    #1 rst = 1'b1;
    #1;
    check("midrst_tick", 32'(tick), 0);
    check("midrst_clk", 32'(sclk), 0);
    check("midrst_ready", 32'(ready), 0);
    step();
    rst = 1'b0;
    for (int i = 1; i < SU; i++) step();
    check("rerelease_ready_lo", 32'(ready), 0);
    step();
    check("rerelease_ready_hi", 32'(ready), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
